// File: rtl/keccak_control.sv
// Sequences one message through the Keccak core: clear state, absorb each rate block, run the rounds, drain the digest.
// Latency: Buffer_full seen in WAIT_BLOCK -> Absorb_en next cycle; NUM_ROUNDS+1 cycles from ABSORB back to WAIT_BLOCK.
// Backpressure: a full buffer is held until WAIT_BLOCK; Ready is the only release back to keccak_buffer.
module keccak_control #(
    parameter int NUM_ROUNDS   = 24,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Din_valid,
    input  logic       Last_block_in,
    input  logic       Buffer_full,
    output logic       State_init,
    output logic       Absorb_en,
    output logic       Perm_en,
    output logic [4:0] Round_number,
    output logic       Ready,
    output logic       Last_block,
    output logic       Busy,
    output logic       Done
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_BLOCK,
        S_ABSORB,
        S_PERMUTE,
        S_SQUEEZE,
        S_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           round_q;
    logic [DRAIN_W-1:0]   drain_q;
    logic                 last_loading_q;
    logic                 last_pending_q;
    logic                 last_seen;
    logic                 last_round;
    logic                 last_drain;

    assign last_seen  = Din_valid & Last_block_in;
    assign last_round = (round_q == 5'(NUM_ROUNDS - 1));
    assign last_drain = (drain_q == DRAIN_W'(DRAIN_CYCLES - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            round_q        <= '0;
            drain_q        <= '0;
            last_loading_q <= 1'b0;
            last_pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_INIT: begin
                    last_loading_q <= 1'b0;
                    last_pending_q <= 1'b0;
                end
                S_WAIT_BLOCK: begin
                    if (last_seen) last_loading_q <= 1'b1;
                end
                S_ABSORB: begin
                    // A last flag arriving in the absorb cycle itself belongs to this block.
                    last_pending_q <= last_loading_q | last_seen;
                    last_loading_q <= 1'b0;
                    round_q        <= '0;
                end
                S_PERMUTE: begin
                    // A flag raised here is for the block now loading, not the one permuting.
                    if (last_seen) last_loading_q <= 1'b1;
                    if (!last_round) round_q <= round_q + 5'd1;
                end
                S_SQUEEZE: begin
                    drain_q <= '0;
                end
                S_DRAIN: begin
                    if (!last_drain) drain_q <= drain_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        State_init   = 1'b0;
        Absorb_en    = 1'b0;
        Perm_en      = 1'b0;
        Round_number = 5'd0;
        Ready        = 1'b0;
        Last_block   = 1'b0;
        Busy         = (state_q != S_IDLE);
        Done         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_INIT;
            end
            S_INIT: begin
                State_init = 1'b1;
                state_d    = S_WAIT_BLOCK;
            end
            S_WAIT_BLOCK: begin
                if (Buffer_full) state_d = S_ABSORB;
            end
            S_ABSORB: begin
                Absorb_en = 1'b1;
                Ready     = 1'b1;
                state_d   = S_PERMUTE;
            end
            S_PERMUTE: begin
                Perm_en      = 1'b1;
                Round_number = round_q;
                if (last_round) state_d = last_pending_q ? S_SQUEEZE : S_WAIT_BLOCK;
            end
            S_SQUEEZE: begin
                Ready      = 1'b1;
                Last_block = 1'b1;
                state_d    = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_drain) begin
                    Done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_keccak_control.sv
// Bench for keccak_control: randomized host/buffer stimulus against a procedural protocol model.
module tb_keccak_control;

    localparam int NR = 24;
    localparam int DC = 5;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       Din_valid;
    logic       Last_block_in;
    logic       Buffer_full;
    logic       State_init;
    logic       Absorb_en;
    logic       Perm_en;
    logic [4:0] Round_number;
    logic       Ready;
    logic       Last_block;
    logic       Busy;
    logic       Done;

    keccak_control #(.NUM_ROUNDS(NR), .DRAIN_CYCLES(DC)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .Din_valid    (Din_valid),
        .Last_block_in(Last_block_in),
        .Buffer_full  (Buffer_full),
        .State_init   (State_init),
        .Absorb_en    (Absorb_en),
        .Perm_en      (Perm_en),
        .Round_number (Round_number),
        .Ready        (Ready),
        .Last_block   (Last_block),
        .Busy         (Busy),
        .Done         (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model: the protocol written as a sequential program ----------------
    logic s_rst, s_start, s_dv, s_lb, s_full;

    function automatic logic [11:0] vec(logic si, logic ab, logic pe, logic [4:0] rn,
                                        logic rd, logic lb, logic bz, logic dn);
        return {si, ab, pe, rn, rd, lb, bz, dn};
    endfunction

    task automatic step(string tag, logic [11:0] e);
        @(negedge Clock);
        check_eq(tag, {20'd0, State_init, Absorb_en, Perm_en, Round_number, Ready, Last_block, Busy, Done},
                 {20'd0, e});
        @(posedge Clock);
        s_rst   = Reset;
        s_start = Start;
        s_dv    = Din_valid;
        s_lb    = Last_block_in;
        s_full  = Buffer_full;
    endtask

    task automatic model_msg();
        bit ll, lp;
        ll = 0;
        lp = 0;
        step("init", vec(1, 0, 0, 5'd0, 0, 0, 1, 0));
        if (s_rst) return;
        forever begin
            do begin
                step("wait", vec(0, 0, 0, 5'd0, 0, 0, 1, 0));
                if (s_rst) return;
                if (s_dv && s_lb) ll = 1;
            end while (!s_full);
            step("absorb", vec(0, 1, 0, 5'd0, 1, 0, 1, 0));
            if (s_rst) return;
            lp = ll | (s_dv & s_lb);
            ll = 0;
            for (int r = 0; r < NR; r++) begin
                step("perm", vec(0, 0, 1, 5'(r), 0, 0, 1, 0));
                if (s_rst) return;
                if (s_dv && s_lb) ll = 1;
            end
            if (lp) break;
        end
        step("squeeze", vec(0, 0, 0, 5'd0, 1, 1, 1, 0));
        if (s_rst) return;
        for (int d = 0; d < DC; d++) begin
            step("drain", vec(0, 0, 0, 5'd0, 0, 0, 1, d == DC - 1));
            if (s_rst) return;
        end
    endtask

    initial begin
        @(posedge Clock);
        forever begin
            step("idle", 12'd0);
            if (!s_rst && s_start) model_msg();
        end
    end

    // ---------------- host + keccak_buffer stand-in ----------------
    bit hq[$];
    int hcnt     = 0;
    bit hfull    = 0;
    bit hdrove   = 0;
    bit noise_en = 0;
    int send_pct = 100;

    task automatic tick();
        @(negedge Clock);
        if (hdrove) begin
            hcnt++;
            if (hcnt == 16) begin
                hcnt  = 0;
                hfull = 1;
            end
        end
        if (Ready && !Last_block) hfull = 0;
        hdrove        = 0;
        Reset         = 1'b0;
        Start         = 1'b0;
        Din_valid     = 1'b0;
        Last_block_in = 1'($urandom_range(0, 1));
        if (!hfull && hq.size() > 0 && $urandom_range(1, 100) <= send_pct) begin
            Din_valid     = 1'b1;
            Last_block_in = hq.pop_front();
            hdrove        = 1;
        end else if (hq.size() == 0 && noise_en && $urandom_range(0, 9) == 0) begin
            Din_valid = 1'b1;
        end
        Buffer_full = hfull;
    endtask

    task automatic do_reset();
        Reset       = 1'b1;
        hq.delete();
        hcnt        = 0;
        hfull       = 0;
        hdrove      = 0;
        Din_valid   = 1'b0;
        Buffer_full = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_message(int nblk, bit last_flag, int pct, int start_rnd, int rst_rnd,
                               bit rst_drain, bit absorb_last);
        int budget;
        int sq;
        bit done;
        bit fired;
        hq.delete();
        for (int b = 0; b < nblk; b++)
            for (int w = 0; w < 16; w++)
                hq.push_back(last_flag && (b == nblk - 1) && (w == 15));
        send_pct = pct;
        done     = 0;
        fired    = 0;
        sq       = -1;
        budget   = 0;
        tick();
        Start = 1'b1;
        while (!done && budget < 4000) begin
            tick();
            budget++;
            if (Done) begin
                done = 1;
            end else begin
                if (start_rnd >= 0 && Perm_en && Round_number == 5'(start_rnd)) Start = 1'b1;
                if (absorb_last && !fired && Absorb_en) begin
                    Din_valid     = 1'b1;
                    Last_block_in = 1'b1;
                    fired         = 1;
                end
                if (sq >= 0) sq++;
                if (Ready && Last_block) sq = 0;
                if ((rst_rnd >= 0 && Perm_en && Round_number == 5'(rst_rnd)) || (rst_drain && sq == 2)) begin
                    do_reset();
                    return;
                end
            end
        end
        if (!done) begin
            check_eq("done_timeout", 32'd0, 32'd1);
            do_reset();
            return;
        end
        hq.delete();
        tick();
    endtask

    initial begin
        Reset         = 1'b1;
        Start         = 1'b0;
        Din_valid     = 1'b0;
        Last_block_in = 1'b0;
        Buffer_full   = 1'b0;
        repeat (3) @(negedge Clock);

        noise_en = 0;
        run_message(1, 1, 100, -1, -1, 0, 0);   // single block
        run_message(2, 1, 100, -1, -1, 0, 0);   // block 2 loads during block 1 rounds, full at round end
        run_message(2, 1, 40,  -1, -1, 0, 0);   // slow host, WAIT_BLOCK dwell
        run_message(2, 1, 100, 10, -1, 0, 0);   // Start during round 10 ignored
        run_message(2, 1, 100, -1,  7, 0, 0);   // reset at round 7
        run_message(1, 1, 100, -1, -1, 0, 0);
        run_message(1, 1, 100, -1, -1, 1, 0);   // reset inside DRAIN
        run_message(1, 1, 100, -1, -1, 0, 0);
        run_message(1, 0, 100, -1, -1, 0, 1);   // last flag only in the ABSORB cycle
        run_message(3, 1, 70,  -1, -1, 0, 0);

        noise_en = 1;
        for (int m = 0; m < 30; m++) begin
            int sr;
            int rr;
            sr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NR - 1)) : -1;
            rr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NR - 1)) : -1;
            run_message(int'($urandom_range(1, 3)), 1, int'($urandom_range(30, 100)), sr, rr,
                        ($urandom_range(0, 14) == 0), 0);
        end
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/keccak_control.md
Name: keccak_control

Overview:
- Top-level sequencer for the Keccak high-speed core, one message at a time.
- Clears the state register and absorbs each full rate block from keccak_buffer into the state.
- Steps the round datapath through NUM_ROUNDS rounds per block.
- After the last block's permutation, switches keccak_buffer into output mode and waits for the digest words to drain.

Parameters:
- NUM_ROUNDS, 24, permutation rounds per block (Keccak-f[1600]).
- DRAIN_CYCLES, 5, cycles keccak_buffer spends in output mode (load + 4 words incl. exit cycle).

Ports:
- Clock  in  1  core clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin a new message; sampled only in IDLE.
- Din_valid  in  1  host word strobe; mirrors keccak_buffer Din_buffer_in_valid.
- Last_block_in  in  1  host flag; with Din_valid, marks the block being loaded as final.
- Buffer_full  in  1  keccak_buffer Din_buffer_full.
- State_init  out  1  clear permutation state register.
- Absorb_en  out  1  XOR Din_buffer_out into state this cycle.
- Perm_en  out  1  apply one round to state this cycle.
- Round_number  out  5  round index for round-constant lookup.
- Ready  out  1  to keccak_buffer Ready.
- Last_block  out  1  to keccak_buffer Last_block.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when the digest has fully drained.

Behaviour:
- Reset (synchronous, active-high): FSM goes to IDLE, counters and flags clear, all outputs 0. Reset wins over every other input, including mid-PERMUTE or mid-DRAIN.
- All outputs are registered or Moore-decoded from state; no input-to-output combinational path.
- IDLE: Busy=0. Start=1 -> INIT.
- INIT (1 cycle): State_init=1, last_loading and last_pending cleared -> WAIT_BLOCK.
- WAIT_BLOCK: Buffer_full=1 -> ABSORB next cycle; otherwise hold.
- ABSORB (1 cycle):
  - Absorb_en=1 and Ready=1, which clears the buffer full flag.
  - last_pending <= last_loading | (Din_valid & Last_block_in); last_loading <= 0.
  - Round counter <= 0; -> PERMUTE.
- PERMUTE (NUM_ROUNDS cycles):
  - Perm_en=1; Round_number = 0..NUM_ROUNDS-1, incrementing by 1 each cycle.
  - On round NUM_ROUNDS-1: last_pending=1 -> SQUEEZE, else -> WAIT_BLOCK.
- SQUEEZE (1 cycle): Ready=1 and Last_block=1 together, putting the buffer in output mode. Drain counter <= 0; -> DRAIN.
- DRAIN: hold for DRAIN_CYCLES cycles. On the last cycle, Done=1 for one cycle -> IDLE.
- Round_number is 0 outside PERMUTE. Ready, Absorb_en, Perm_en, State_init and Last_block are 0 in all states except those listed above.
- last_loading is set by Din_valid & Last_block_in in WAIT_BLOCK or PERMUTE. It is sticky until ABSORB. A last flag raised while block k permutes therefore applies to block k+1.
- If Din_valid & Last_block_in occurs in the ABSORB cycle itself, it is folded into last_pending for the block being absorbed (boundary case).
- Start outside IDLE is ignored; Din_valid in IDLE, SQUEEZE or DRAIN is ignored.
- Buffer_full may rise during PERMUTE. The controller does not react until WAIT_BLOCK, so the buffer holds the block.
- Per-block latency:
  - Buffer_full seen in WAIT_BLOCK -> Absorb_en next cycle.
  - First Perm_en the cycle after that; NUM_ROUNDS+1 cycles from ABSORB to the next WAIT_BLOCK.
- Counter widths: round counter 5 bits, must not wrap inside PERMUTE; drain counter sized for DRAIN_CYCLES.

Test Plan:
- Single block: Reset, Start, 16 Din_valid words with Last_block_in on word 16.
  - Required sequence: State_init 1 cycle; ABSORB the cycle after Buffer_full; Perm_en 24 cycles with Round_number 0..23.
  - Then Ready+Last_block 1 cycle, Done exactly 5 cycles later, Busy=0 after Done.
- Two blocks, last flagged on block 2 only: two ABSORB/PERMUTE passes (2x25 cycles); first pass returns to WAIT_BLOCK; SQUEEZE only after the second.
- Block 2 loaded with Last_block_in while block 1 permutes: block 1 ends in WAIT_BLOCK; SQUEEZE follows block 2's permutation.
- Buffer_full already high when PERMUTE ends: ABSORB occurs the cycle after WAIT_BLOCK is entered; Ready pulses exactly once per block.
- Start pulsed during PERMUTE (round 10): no State_init, Round_number continues 11,12,...
- Reset asserted at round 7 and again in DRAIN: next cycle all outputs 0, FSM in IDLE. A fresh Start then runs the single-block sequence correctly.
